// File: rtl/ram_arb_wide_pkg.sv
// Shared constants for the ram_arb_wide block.
//   BYTE_W        : width of one byte lane (8)
//   MIN/MAX_PORTS : legal requester-channel range
//   ports_legal() : true for a supported NUM_PORTS
//   bytes_legal() : true for a supported DATA_BYTES (1, 2 or 4)
package ram_arb_wide_pkg;

  localparam int BYTE_W    = 8;
  localparam int MIN_PORTS = 1;
  localparam int MAX_PORTS = 4;

  function automatic bit ports_legal(input int n);
    return (n >= MIN_PORTS) && (n <= MAX_PORTS);
  endfunction

  function automatic bit bytes_legal(input int b);
    return (b == 1) || (b == 2) || (b == 4);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; also forces grant to zero
//   valid : per-port request
//   grant : one-hot (or zero) combinational grant
// Search starts at the priority pointer; after a grant to port i the
// pointer moves to (i+1) mod NUM_PORTS, otherwise it holds.
module rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] valid,
  output logic [NUM_PORTS-1:0] grant
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  int            win;
  int            idx;
  logic          any;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    win     = 0;
    idx     = 0;
    any     = 1'b0;
    // Walk from the farthest offset inward so the nearest requester to
    // the pointer is the last one recorded.
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NUM_PORTS;
      if (valid[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
    if (rst_n && any) begin
      grant[win] = 1'b1;
      ptr_nxt    = PW'((win + 1) % NUM_PORTS);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

endmodule

// File: rtl/single_port_ram_sync.sv
// Single-port synchronous RAM, read-first, one-cycle read latency.
//   clk   : rising-edge clock
//   we    : write enable for the addressed word
//   addr  : word address
//   wdata : write data
//   rdata : registered read data of the word addressed at the previous edge
// Contents are never initialised.
module single_port_ram_sync #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_arb_wide.sv
// Multi-port arbitrated byte-lane RAM.
//   clk_in        : system clock (rising edge)
//   rst_n_in      : synchronous active-low reset
//   req_valid_in  : per-port request valid
//   req_ready_out : per-port grant, at most one set, combinational
//   req_we_in     : per-port write select (1 write, 0 read)
//   req_addr_in   : packed word addresses, port i at slice i
//   req_wdata_in  : packed write data
//   req_wstrb_in  : packed byte-lane strobes
//   rsp_valid_out : one-hot read-response pulse, one cycle after accept
//   rsp_data_out  : shared read data, zero when no response
module ram_arb_wide
  import ram_arb_wide_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_BYTES = 4,
  parameter int NUM_PORTS  = 2
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic [NUM_PORTS-1:0]                req_valid_in,
  output logic [NUM_PORTS-1:0]                req_ready_out,
  input  logic [NUM_PORTS-1:0]                req_we_in,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr_in,
  input  logic [NUM_PORTS*BYTE_W*DATA_BYTES-1:0] req_wdata_in,
  input  logic [NUM_PORTS*DATA_BYTES-1:0]     req_wstrb_in,
  output logic [NUM_PORTS-1:0]                rsp_valid_out,
  output logic [BYTE_W*DATA_BYTES-1:0]        rsp_data_out
);

  localparam int DW = BYTE_W * DATA_BYTES;

  generate
    if (!ports_legal(NUM_PORTS)) begin : g_bad_ports
      $error("ram_arb_wide: NUM_PORTS must be 1..4");
    end
    if (!bytes_legal(DATA_BYTES)) begin : g_bad_bytes
      $error("ram_arb_wide: DATA_BYTES must be 1, 2 or 4");
    end
  endgenerate

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DW-1:0]         wdata;
    logic [DATA_BYTES-1:0] wstrb;
  } req_t;

  logic [NUM_PORTS-1:0]  grant;
  logic                  granted;
  req_t                  sel;
  logic [DATA_BYTES-1:0] lane_we;
  logic [DW-1:0]         rdata;
  logic [NUM_PORTS-1:0]  rsp_tag;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .valid (req_valid_in),
    .grant (grant)
  );

  assign req_ready_out = grant;
  assign granted       = |grant;

  // Grant is one-hot, so the winner's fields simply steer the RAM.
  always_comb begin
    sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        sel.we    = req_we_in[p];
        sel.addr  = req_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel.wdata = req_wdata_in[p*DW +: DW];
        sel.wstrb = req_wstrb_in[p*DATA_BYTES +: DATA_BYTES];
      end
    end
  end

  genvar l;
  generate
    for (l = 0; l < DATA_BYTES; l++) begin : g_lane
      assign lane_we[l] = granted & sel.we & sel.wstrb[l];
      single_port_ram_sync #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (BYTE_W)
      ) u_ram (
        .clk   (clk_in),
        .we    (lane_we[l]),
        .addr  (sel.addr),
        .wdata (sel.wdata[l*BYTE_W +: BYTE_W]),
        .rdata (rdata[l*BYTE_W +: BYTE_W])
      );
    end
  endgenerate

  // Port tag of the read accepted at the last edge; writes leave no tag.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) rsp_tag <= '0;
    else           rsp_tag <= grant & ~req_we_in;
  end

  // Reset masks the response combinationally so a read accepted just
  // before reset asserts never becomes visible.
  assign rsp_valid_out = rsp_tag & {NUM_PORTS{rst_n_in}};
  assign rsp_data_out  = (|rsp_valid_out) ? rdata : '0;

endmodule

// File: tb/tb_ram_arb_wide.sv
module tb_ram_arb_wide;
  localparam int AW = 15;
  localparam int DB = 4;
  localparam int NP = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [NP-1:0]    valid = '0;
  logic [NP-1:0]    we    = '0;
  logic [NP*AW-1:0] addr  = '0;
  logic [NP*DW-1:0] wdata = '0;
  logic [NP*DB-1:0] wstrb = '0;
  logic [NP-1:0]    ready;
  logic [NP-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;

  // Single-port, single-lane instance
  logic          rst1_n = 1'b0;
  logic [0:0]    valid1 = '0;
  logic [0:0]    we1    = '0;
  logic [AW-1:0] addr1  = '0;
  logic [7:0]    wdata1 = '0;
  logic [0:0]    wstrb1 = '0;
  logic [0:0]    ready1;
  logic [0:0]    rsp_valid1;
  logic [7:0]    rsp_data1;

  ram_arb_wide #(.ADDR_WIDTH(AW), .DATA_BYTES(DB), .NUM_PORTS(NP)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(valid), .req_ready_out(ready),
    .req_we_in(we), .req_addr_in(addr), .req_wdata_in(wdata), .req_wstrb_in(wstrb),
    .rsp_valid_out(rsp_valid), .rsp_data_out(rsp_data));

  ram_arb_wide #(.ADDR_WIDTH(AW), .DATA_BYTES(1), .NUM_PORTS(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst1_n), .req_valid_in(valid1), .req_ready_out(ready1),
    .req_we_in(we1), .req_addr_in(addr1), .req_wdata_in(wdata1), .req_wstrb_in(wstrb1),
    .rsp_valid_out(rsp_valid1), .rsp_data_out(rsp_data1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_ptr = 0;
  logic [DW-1:0] m_mem   [int];
  logic [DB-1:0] m_known [int];
  logic [NP-1:0] m_rsp   = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [DB-1:0] m_rmask = '0;

  function automatic logic [NP-1:0] m_grant(input logic [NP-1:0] v, input int p, input logic r);
    if (!r) return '0;
    for (int k = 0; k < NP; k++) begin
      int i;
      i = (p + k) % NP;
      if (v[i]) return NP'(1) << i;
    end
    return '0;
  endfunction

  always @(posedge clk) begin
    logic [NP-1:0] g;
    g = m_grant(valid, m_ptr, rst_n);
    m_rsp = '0;
    if (!rst_n) begin
      m_ptr = 0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (g[i]) begin
          int a;
          a = int'(addr[i*AW +: AW]);
          if (!m_mem.exists(a)) begin m_mem[a] = '0; m_known[a] = '0; end
          if (we[i]) begin
            for (int b = 0; b < DB; b++)
              if (wstrb[i*DB + b]) begin
                m_mem[a][b*8 +: 8] = wdata[i*DW + b*8 +: 8];
                m_known[a][b] = 1'b1;
              end
          end else begin
            m_rsp[i] = 1'b1;
            m_rdata  = m_mem[a];
            m_rmask  = m_known[a];
          end
          m_ptr = (i + 1) % NP;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [NP-1:0] exp_rv;
    logic [DW-1:0] bm;
    check("ready", 64'(ready), 64'(m_grant(valid, m_ptr, rst_n)));
    exp_rv = rst_n ? m_rsp : '0;
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv == '0) begin
      check("rsp_data_idle", 64'(rsp_data), 64'd0);
    end else begin
      bm = '0;
      for (int b = 0; b < DB; b++) if (m_rmask[b]) bm[b*8 +: 8] = 8'hFF;
      check("rsp_data", 64'(rsp_data & bm), 64'(m_rdata & bm));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_req(input int p, input bit w, input int a, input logic [31:0] d, input logic [3:0] s);
    bit ok;
    valid = '0; valid[p] = 1'b1;
    we = '0; we[p] = w;
    addr[p*AW +: AW] = AW'(a);
    wdata[p*DW +: DW] = d;
    wstrb[p*DB +: DB] = s;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (ready[p]) ok = 1'b1;
      tick();
    end
    valid = '0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: port %0d never granted, expected grant within 10 cycles", p);
    end
  endtask

  initial begin
    int c0, c1;
    logic [NP-1:0] g;

    // Reset with both ports requesting: no grants, no response
    valid = 2'b11; we = 2'b11; wstrb = '1;
    tick(); tick();
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);

    // Continuous contention right from reset release
    we = 2'b00; wstrb = '0; addr = '0;
    @(posedge clk); #1;
    rst_n = 1'b1; rst1_n = 1'b1;
    c0 = 0; c1 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      g = ready;
      check("rr_grant", 64'(g), (c % 2 == 0) ? 64'h1 : 64'h2);
      c0 += int'(g[0]); c1 += int'(g[1]);
      tick();
    end
    valid = '0;
    check("rr_share_p0", 64'(c0), 64'd4);
    check("rr_share_p1", 64'(c1), 64'd4);
    tick();

    // Full write then read-back on port 0
    do_req(0, 1'b1, 5, 32'h11223344, 4'hF);
    do_req(0, 1'b0, 5, 32'h0, 4'h0);
    @(negedge clk);
    check("full_rd_valid", 64'(rsp_valid), 64'h1);
    check("full_rd_data", 64'(rsp_data), 64'h11223344);
    tick();

    // Partial write on lanes 0 and 2
    do_req(0, 1'b1, 5, 32'hAABBCCDD, 4'h5);
    do_req(0, 1'b0, 5, 32'h0, 4'h0);
    @(negedge clk);
    check("part_rd_data", 64'(rsp_data), 64'h11BB33DD);
    tick();

    // All-zero strobe write leaves memory unchanged
    do_req(1, 1'b1, 5, 32'hFFFFFFFF, 4'h0);
    do_req(1, 1'b0, 5, 32'h0, 4'h0);
    @(negedge clk);
    check("zstrb_valid", 64'(rsp_valid), 64'h2);
    check("zstrb_data", 64'(rsp_data), 64'h11BB33DD);
    tick();

    // Top address: write on port 0, read on port 1 next cycle
    do_req(0, 1'b1, 32'h7FFF, 32'hCAFEF00D, 4'hF);
    do_req(1, 1'b0, 32'h7FFF, 32'h0, 4'h0);
    @(negedge clk);
    check("top_rd_valid", 64'(rsp_valid), 64'h2);
    check("top_rd_data", 64'(rsp_data), 64'hCAFEF00D);
    tick();

    // Back-to-back reads from both ports
    addr[0 +: AW] = AW'(5); addr[AW +: AW] = AW'(32'h7FFF);
    we = 2'b00; valid = 2'b11;
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("b2b_rsp_any", 64'(rsp_valid != 0), 64'd1);
      tick();
    end
    valid = '0;
    tick();

    // Read accepted on port 0 (pointer moves to 1), then reset
    do_req(0, 1'b0, 5, 32'h0, 4'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_kill_valid", 64'(rsp_valid), 64'd0);
    check("rst_kill_data", 64'(rsp_data), 64'd0);
    valid = 2'b11;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", 64'(ready), 64'h1);
    tick();
    valid = '0;
    tick();

    // Mixed traffic, checked by the model each cycle
    for (int c = 0; c < 40; c++) begin
      valid = NP'($urandom);
      we    = NP'($urandom);
      wstrb = (NP*DB)'($urandom);
      wdata = {$urandom, $urandom};
      for (int p = 0; p < NP; p++) begin
        int sel;
        sel = int'($urandom_range(0, 3));
        addr[p*AW +: AW] = (sel == 3) ? AW'(32'h7FFF) : AW'(5 + sel);
      end
      tick();
    end
    valid = '0;
    tick(); tick();

    // Single-port, single-lane: write top address then read next cycle
    valid1 = 1'b1; we1 = 1'b1; addr1 = AW'(32'h7FFF); wdata1 = 8'h5A; wstrb1 = 1'b1;
    @(negedge clk);
    check("p1_wr_ready", 64'(ready1), 64'h1);
    tick();
    we1 = 1'b0; wdata1 = 8'h00;
    @(negedge clk);
    check("p1_rd_ready", 64'(ready1), 64'h1);
    check("p1_wr_no_rsp", 64'(rsp_valid1), 64'h0);
    tick();
    valid1 = 1'b0;
    @(negedge clk);
    check("p1_rd_valid", 64'(rsp_valid1), 64'h1);
    check("p1_rd_data", 64'(rsp_data1), 64'h5A);
    tick();
    @(negedge clk);
    check("p1_idle_valid", 64'(rsp_valid1), 64'h0);
    check("p1_idle_data", 64'(rsp_data1), 64'h0);
    check("p1_idle_ready", 64'(ready1), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
